mprj_pad_cfg_sequencer: RTL and testbench
=========================================

// Module: mprj_pad_cfg_sequencer
// PURPOSE
//  Parametrised config stage that sits between the management core and the user-project pad ring.
//  - Loads one configuration word per pad into shadow registers over a valid/ready stream.
//  - Applies the shadow registers to the live pad-control outputs one group at a time.
//  - A programmable gap between groups limits simultaneous pad switching on the vddio/vssio rails.
//  - Replaces the static per-pad control wiring with a sequenced, scalable update path.
// PARAMETERS
//  NUM_PADS   38       number of user pads configured
//  GROUP      4        pads applied per apply step (1..NUM_PADS)
//  STAGGER    2        idle cycles between consecutive apply steps (0 = back-to-back)
//  RESET_CFG  13'h0402 per-pad value on reset: dm=3'b001 (input), oeb=1, all other fields 0
// PORTS
//  clock       in   1              system clock
//  resetb      in   1              async active-low reset
//  load_start  in   1              pulse: begin a load sequence (honoured only in IDLE)
//  load_abort  in   1              leave LOAD, discard sequence (live outputs untouched)
//  cfg_valid   in   1              cfg_data valid
//  cfg_ready   out  1              high only in LOAD
//  cfg_data    in   13             config word for the next pad (pads taken 0..NUM_PADS-1)
//  pad_cfg     out  NUM_PADS*13    live config, pad i at [13*i +: 13]
//  busy        out  1              high in LOAD/APPLY/WAIT
//  done        out  1              1-cycle pulse after the final group is applied
// BEHAVIOUR
//  Word layout: [12:10] dm, [9] vtrip_sel, [8] slow_sel, [7] analog_pol, [6] analog_sel,
//    [5] analog_en, [4] ib_mode_sel, [3] inp_dis, [2] holdover, [1] oeb, [0] mgmt_en.
//  Reset values: pad_cfg and all shadows = RESET_CFG per pad; cfg_ready=0, busy=0, done=0;
//    state=IDLE; pad and group counters = 0.
//  FSM: IDLE -> LOAD on load_start.
//    LOAD: writes shadow[pad_idx] on each cfg_valid&cfg_ready edge.
//      Moves to APPLY on the edge that accepts pad NUM_PADS-1.
//      load_abort -> IDLE; words already written stay in the shadows; pad_cfg is unchanged.
//      load_abort has priority over a handshake in the same cycle.
//    APPLY: on the next edge, live pads [g*GROUP, min((g+1)*GROUP, NUM_PADS)-1] <= shadow.
//      Then -> WAIT if STAGGER>0 and groups remain; -> APPLY if STAGGER==0 and groups remain;
//      -> DONE after the last group.
//    WAIT: STAGGER cycles, then -> APPLY.
//    DONE: done=1 for exactly one cycle, busy=0 in that cycle, then -> IDLE.
//  Timing: group k is applied at edge E1 + k*(STAGGER+1), where E1 is the first edge after
//    the final handshake. Defaults: 10 groups; last group at E28; done high E28..E29.
//  Last group is partial when NUM_PADS % GROUP != 0; pads beyond NUM_PADS-1 are never addressed.
//  load_start when not in IDLE is ignored; load_abort outside LOAD is ignored.
//  Live outputs change only at apply edges and are glitch-free (registered).
//  Async reset mid-sequence: everything returns to reset values immediately.
//  Counters: pad_idx is $clog2(NUM_PADS) bits; group and stagger counters are sized
//    likewise; none wraps past its terminal value.
// CONFIGURATION
//  PAD_CFG_READBACK_EN defined:
//    - adds ports rb_addr (in, $clog2(NUM_PADS)) and rb_data (out, 13).
//    - rb_data is registered: it returns the live pad_cfg of rb_addr one cycle later.
//    - rb_data resets to RESET_CFG; an out-of-range rb_addr returns 13'h0.
//  PAD_CFG_READBACK_EN undefined: the ports and logic are absent; behaviour is otherwise identical.
// STRUCTURE
//  Package pad_cfg_pkg: CFG_W=13, field bit-offset localparams, the default RESET_CFG value,
//    and the state enum {IDLE, LOAD, APPLY, WAIT, DONE}.
//  Sub-module pad_cfg_stagger_cnt: loadable down-counter for WAIT; inputs load/en, output
//    zero flag. The top level holds the FSM, shadow array, live array and optional readback.
// TESTING
//  Reset: assert resetb=0 -> pad_cfg all 13'h0402, busy=0, cfg_ready=0, done=0.
//  Full load, defaults: pad i gets 13'h1000|i, cfg_valid held high. Check:
//    - no live change during LOAD;
//    - groups land 3 cycles apart, pads 36..37 last;
//    - single done pulse 28 edges after the final handshake.
//  Backpressure and abort:
//    - gapped cfg_valid -> accept order preserved;
//    - load_abort after 5 pads -> IDLE, pad_cfg unchanged;
//    - a fresh full load then overwrites all pads.
//  Ignored and simultaneous events:
//    - load_start during APPLY -> no effect, sequence completes normally;
//    - load_abort together with a valid handshake -> abort wins, that word is not counted.
//  Corner parameters:
//    - NUM_PADS=5, GROUP=5, STAGGER=0 -> one step, done one edge later;
//    - GROUP=1, STAGGER=0 -> one pad per edge.
//  Reset mid-APPLY at group 4 -> all outputs RESET_CFG. With PAD_CFG_READBACK_EN:
//    rb_addr=7 -> rb_data equals pad 7 one cycle later.

Source files
------------

// File: rtl/pad_cfg_pkg.sv
// rtl/pad_cfg_pkg.sv - shared widths, pad word field offsets, reset value and FSM states
package pad_cfg_pkg;

  localparam int CFG_W = 13;

  localparam int DM_LSB          = 10;
  localparam int VTRIP_SEL_BIT   = 9;
  localparam int SLOW_SEL_BIT    = 8;
  localparam int ANALOG_POL_BIT  = 7;
  localparam int ANALOG_SEL_BIT  = 6;
  localparam int ANALOG_EN_BIT   = 5;
  localparam int IB_MODE_SEL_BIT = 4;
  localparam int INP_DIS_BIT     = 3;
  localparam int HOLDOVER_BIT    = 2;
  localparam int OEB_BIT         = 1;
  localparam int MGMT_EN_BIT     = 0;

  // dm=3'b001 (input buffer), oeb=1 (output disabled), everything else off
  localparam logic [CFG_W-1:0] RESET_CFG_DEFAULT = 13'h0402;

  typedef enum logic [2:0] {IDLE, LOAD, APPLY, WAIT, DONE} state_t;

  // Counter width for values 0..n-1, never narrower than one bit
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pad_cfg_stagger_cnt.sv
// rtl/pad_cfg_stagger_cnt.sv - loadable, non-wrapping down-counter timing the gap between apply steps
module pad_cfg_stagger_cnt #(
  parameter int W = 1
) (
  input  logic         clock,
  input  logic         resetb,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/mprj_pad_cfg_sequencer.sv
// rtl/mprj_pad_cfg_sequencer.sv - shadow-load then group-staggered apply of user pad configuration
// Optional live readback port enabled by PAD_CFG_READBACK_EN.
module mprj_pad_cfg_sequencer
  import pad_cfg_pkg::*;
#(
  parameter int               NUM_PADS  = 38,
  parameter int               GROUP     = 4,
  parameter int               STAGGER   = 2,
  parameter logic [CFG_W-1:0] RESET_CFG = RESET_CFG_DEFAULT,
  localparam int NUM_GROUPS = (NUM_PADS + GROUP - 1) / GROUP,
  localparam int PAD_W      = cnt_w(NUM_PADS),
  localparam int GRP_W      = cnt_w(NUM_GROUPS),
  localparam int STG_W      = cnt_w(STAGGER)
) (
  input  logic                      clock,
  input  logic                      resetb,
  input  logic                      load_start,
  input  logic                      load_abort,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  input  logic [CFG_W-1:0]          cfg_data,
  output logic [NUM_PADS*CFG_W-1:0] pad_cfg,
  output logic                      busy,
  output logic                      done
`ifdef PAD_CFG_READBACK_EN
  ,
  input  logic [PAD_W-1:0]          rb_addr,
  output logic [CFG_W-1:0]          rb_data
`endif
);

  state_t state, state_nx;

  logic [PAD_W-1:0] pad_idx;
  logic [GRP_W-1:0] grp_idx;
  logic [CFG_W-1:0] shadow [NUM_PADS];
  logic [CFG_W-1:0] live   [NUM_PADS];

  logic accept, last_pad, last_grp;
  logic stg_load, stg_en, stg_zero;

  // Abort outranks a same-cycle handshake, so the word is neither stored nor counted
  assign accept   = (state == LOAD) && cfg_valid && !load_abort;
  assign last_pad = (pad_idx == PAD_W'(NUM_PADS - 1));
  assign last_grp = (grp_idx == GRP_W'(NUM_GROUPS - 1));
  assign stg_en   = (state == WAIT);

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    stg_load = 1'b0;
    case (state)
      IDLE:  if (load_start) state_nx = LOAD;
      LOAD: begin
        if (load_abort)                state_nx = IDLE;
        else if (accept && last_pad)   state_nx = APPLY;
      end
      APPLY: begin
        if (last_grp) begin
          state_nx = DONE;
        end else if (STAGGER > 0) begin
          state_nx = WAIT;
          stg_load = 1'b1;
        end else begin
          state_nx = APPLY;
        end
      end
      WAIT:  if (stg_zero) state_nx = APPLY;
      DONE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Loaded with STAGGER-1 on the apply edge; WAIT then lasts exactly STAGGER cycles
  pad_cfg_stagger_cnt #(.W(STG_W)) u_stagger_cnt (
    .clock    (clock),
    .resetb   (resetb),
    .load     (stg_load),
    .en       (stg_en),
    .load_val (STG_W'(STAGGER - 1)),
    .zero     (stg_zero)
  );

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      pad_idx <= '0;
      grp_idx <= '0;
    end else begin
      if (state != LOAD)   pad_idx <= '0;
      else if (accept)     pad_idx <= last_pad ? '0 : pad_idx + 1'b1;

      if (state == APPLY)  grp_idx <= last_grp ? '0 : grp_idx + 1'b1;
      else if (state == IDLE) grp_idx <= '0;
    end
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      for (int i = 0; i < NUM_PADS; i++) shadow[i] <= RESET_CFG;
    end else if (accept) begin
      shadow[pad_idx] <= cfg_data;
    end
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      for (int i = 0; i < NUM_PADS; i++) live[i] <= RESET_CFG;
    end else if (state == APPLY) begin
      for (int i = 0; i < NUM_PADS; i++) begin
        if (GRP_W'(i / GROUP) == grp_idx) live[i] <= shadow[i];
      end
    end
  end

  for (genvar g = 0; g < NUM_PADS; g++) begin : g_pad_out
    assign pad_cfg[CFG_W*g +: CFG_W] = live[g];
  end

  assign cfg_ready = (state == LOAD);
  assign busy      = (state == LOAD) || (state == APPLY) || (state == WAIT);
  assign done      = (state == DONE);

`ifdef PAD_CFG_READBACK_EN
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      rb_data <= RESET_CFG;
    end else if (int'(rb_addr) < NUM_PADS) begin
      rb_data <= live[rb_addr];
    end else begin
      rb_data <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_mprj_pad_cfg_sequencer.sv
// tb/tb_mprj_pad_cfg_sequencer.sv - directed scoreboard bench for the pad config sequencer
module tb_mprj_pad_cfg_sequencer;
  import pad_cfg_pkg::*;

  localparam int NP = 38;
  localparam int GR = 4;
  localparam int ST = 2;
  localparam int NG = 10;
  localparam int VW = NP * 13;
  localparam int LAST_EDGE = 1 + (NG - 1) * (ST + 1);

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic resetb;
  logic load_start, load_abort, cfg_valid, cfg_ready, busy, done;
  logic [12:0] cfg_data;
  logic [VW-1:0] pad_cfg;

  logic a_load_start, a_load_abort, a_cfg_valid, a_cfg_ready, a_busy, a_done;
  logic [12:0] a_cfg_data;
  logic [64:0] a_pad_cfg, a_exp;

  logic b_load_start, b_load_abort, b_cfg_valid, b_cfg_ready, b_busy, b_done;
  logic [12:0] b_cfg_data;
  logic [77:0] b_pad_cfg, b_exp;

`ifdef PAD_CFG_READBACK_EN
  logic [5:0]  rb_addr;
  logic [12:0] rb_data;
  logic [2:0]  a_rb_addr, b_rb_addr;
  logic [12:0] a_rb_data, b_rb_data;
`endif

  mprj_pad_cfg_sequencer u_dut (
    .clock(clock), .resetb(resetb), .load_start(load_start), .load_abort(load_abort),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_data(cfg_data),
    .pad_cfg(pad_cfg), .busy(busy), .done(done)
`ifdef PAD_CFG_READBACK_EN
    , .rb_addr(rb_addr), .rb_data(rb_data)
`endif
  );

  mprj_pad_cfg_sequencer #(.NUM_PADS(5), .GROUP(5), .STAGGER(0)) u_one (
    .clock(clock), .resetb(resetb), .load_start(a_load_start), .load_abort(a_load_abort),
    .cfg_valid(a_cfg_valid), .cfg_ready(a_cfg_ready), .cfg_data(a_cfg_data),
    .pad_cfg(a_pad_cfg), .busy(a_busy), .done(a_done)
`ifdef PAD_CFG_READBACK_EN
    , .rb_addr(a_rb_addr), .rb_data(a_rb_data)
`endif
  );

  mprj_pad_cfg_sequencer #(.NUM_PADS(6), .GROUP(1), .STAGGER(0)) u_g1 (
    .clock(clock), .resetb(resetb), .load_start(b_load_start), .load_abort(b_load_abort),
    .cfg_valid(b_cfg_valid), .cfg_ready(b_cfg_ready), .cfg_data(b_cfg_data),
    .pad_cfg(b_pad_cfg), .busy(b_busy), .done(b_done)
`ifdef PAD_CFG_READBACK_EN
    , .rb_addr(b_rb_addr), .rb_data(b_rb_data)
`endif
  );

  int checks = 0;
  int failures = 0;

  typedef struct {
    int          pad;
    logic [12:0] val;
  } sb_t;
  sb_t sb_q[$];
  logic [12:0] exp_live [NP];

  task automatic chk_v(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  function automatic logic [VW-1:0] exp_vec();
    logic [VW-1:0] v;
    for (int i = 0; i < NP; i++) v[13*i +: 13] = exp_live[i];
    return v;
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic start_load();
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    chk_b("load_ready", cfg_ready, 1'b1);
    chk_b("load_busy", busy, 1'b1);
  endtask

  task automatic load_words(input int n, input logic [12:0] base, input bit gapped);
    for (int i = 0; i < n; i++) begin
      if (gapped && (i % 3 == 1)) begin
        cfg_valid = 1'b0;
        step();
        chk_v("gap_live_hold", pad_cfg, exp_vec());
      end
      cfg_valid = 1'b1;
      cfg_data  = base | 13'(i);
      sb_q.push_back('{pad: i, val: base | 13'(i)});
      step();
      chk_v("load_live_hold", pad_cfg, exp_vec());
    end
    cfg_valid = 1'b0;
  endtask

  // Edge n counts from the final handshake; group k lands at n = 1 + k*(ST+1)
  task automatic apply_watch(input int stop_n, input int ls_at);
    bit seen = 1'b0;
    for (int n = 1; n <= 40 && !seen; n++) begin
      if (n == ls_at) load_start = 1'b1;
      step();
      load_start = 1'b0;
      if (((n - 1) % (ST + 1)) == 0) begin
        for (int j = 0; j < GR && sb_q.size() > 0; j++) begin
          sb_t e = sb_q.pop_front();
          exp_live[e.pad] = e.val;
        end
      end
      chk_v("apply_live", pad_cfg, exp_vec());
      chk_b("apply_done", done, n == LAST_EDGE);
      chk_b("apply_busy", busy, n != LAST_EDGE);
      chk_b("apply_ready", cfg_ready, 1'b0);
      if (n == stop_n) return;
      if (done) seen = 1'b1;
    end
    step();
    chk_b("done_single_pulse", done, 1'b0);
    chk_b("idle_busy", busy, 1'b0);
  endtask

  initial begin
    resetb = 1'b0;
    load_start = 0; load_abort = 0; cfg_valid = 0; cfg_data = '0;
    a_load_start = 0; a_load_abort = 0; a_cfg_valid = 0; a_cfg_data = '0;
    b_load_start = 0; b_load_abort = 0; b_cfg_valid = 0; b_cfg_data = '0;
`ifdef PAD_CFG_READBACK_EN
    rb_addr = '0; a_rb_addr = '0; b_rb_addr = '0;
`endif
    for (int i = 0; i < NP; i++) exp_live[i] = 13'h0402;
    step();
    step();
    chk_v("reset_pad_cfg", pad_cfg, exp_vec());
    chk_b("reset_busy", busy, 1'b0);
    chk_b("reset_ready", cfg_ready, 1'b0);
    chk_b("reset_done", done, 1'b0);
    resetb = 1'b1;
    step();

    // Full gapless load with default parameters
    start_load();
    load_words(NP, 13'h1000, 1'b0);
    apply_watch(0, 0);

`ifdef PAD_CFG_READBACK_EN
    rb_addr = 6'd7;
    step();
    step();
    chk_v("readback_pad7", VW'(rb_data), VW'(exp_live[7]));
    rb_addr = 6'd40;
    step();
    step();
    chk_v("readback_out_of_range", VW'(rb_data), VW'(13'h0));
`endif

    // Gapped partial load then abort: live outputs untouched
    start_load();
    load_words(5, 13'h0A00, 1'b1);
    load_abort = 1'b1;
    step();
    load_abort = 1'b0;
    sb_q.delete();
    chk_b("abort_ready", cfg_ready, 1'b0);
    chk_b("abort_busy", busy, 1'b0);
    chk_v("abort_live", pad_cfg, exp_vec());

    // Fresh gapped load overwrites everything; load_start during APPLY is ignored
    start_load();
    load_words(NP, 13'h0500, 1'b1);
    apply_watch(0, 1);
    chk_b("ignored_start_ready", cfg_ready, 1'b0);

    // Abort together with the final handshake: abort wins, nothing is applied
    start_load();
    load_words(NP - 1, 13'h0300, 1'b0);
    cfg_valid = 1'b1;
    cfg_data = 13'h1FFF;
    load_abort = 1'b1;
    step();
    cfg_valid = 1'b0;
    load_abort = 1'b0;
    sb_q.delete();
    chk_b("abort_hs_ready", cfg_ready, 1'b0);
    chk_b("abort_hs_busy", busy, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk_v("abort_hs_live", pad_cfg, exp_vec());
      chk_b("abort_hs_done", done, 1'b0);
    end

    // Async reset right after group 4 has been applied
    start_load();
    load_words(NP, 13'h0C00, 1'b0);
    apply_watch(1 + 4 * (ST + 1), 0);
    resetb = 1'b0;
    #1;
    for (int i = 0; i < NP; i++) exp_live[i] = 13'h0402;
    sb_q.delete();
    chk_v("midreset_pad_cfg", pad_cfg, exp_vec());
    chk_b("midreset_busy", busy, 1'b0);
    chk_b("midreset_done", done, 1'b0);
    chk_b("midreset_ready", cfg_ready, 1'b0);
    step();
    resetb = 1'b1;
    step();

    // NUM_PADS=5, GROUP=5, STAGGER=0: single apply step
    for (int i = 0; i < 5; i++) a_exp[13*i +: 13] = 13'h0402;
    a_load_start = 1'b1;
    step();
    a_load_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      a_cfg_valid = 1'b1;
      a_cfg_data  = 13'h1100 | 13'(i);
      step();
      chk_v("one_load_hold", VW'(a_pad_cfg), VW'(a_exp));
    end
    a_cfg_valid = 1'b0;
    for (int i = 0; i < 5; i++) a_exp[13*i +: 13] = 13'h1100 | 13'(i);
    step();
    chk_v("one_applied", VW'(a_pad_cfg), VW'(a_exp));
    chk_b("one_done", a_done, 1'b1);
    chk_b("one_done_busy", a_busy, 1'b0);
    step();
    chk_b("one_done_end", a_done, 1'b0);

    // GROUP=1, STAGGER=0: one pad per edge
    for (int i = 0; i < 6; i++) b_exp[13*i +: 13] = 13'h0402;
    b_load_start = 1'b1;
    step();
    b_load_start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      b_cfg_valid = 1'b1;
      b_cfg_data  = 13'h1200 | 13'(i);
      step();
    end
    b_cfg_valid = 1'b0;
    chk_v("g1_load_hold", VW'(b_pad_cfg), VW'(b_exp));
    for (int n = 1; n <= 6; n++) begin
      step();
      b_exp[13*(n-1) +: 13] = 13'h1200 | 13'(n - 1);
      chk_v("g1_apply", VW'(b_pad_cfg), VW'(b_exp));
      chk_b("g1_done", b_done, n == 6);
    end
    step();
    chk_b("g1_done_end", b_done, 1'b0);
    chk_b("g1_idle_busy", b_busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
